// File: rtl/cpe_column_sequencer.sv
// Sequencer for one column of ROWS compensation processing elements.
// A pass preloads ROWS 3-bit weights into the column, streams vec_len 7-bit
// activations into it, and then waits until the last activation's
// compensation sum has come out of the bottom CPE.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; both readies low
// LOAD   | accepting ROWS weights and forwarding them down the column
// STREAM | accepting vec_len activations and forwarding them
// DRAIN  | no new valids; waiting for the result pipeline to empty
// DONE   | one-cycle done pulse, then back to IDLE

module cpe_column_sequencer #(
  parameter int ROWS  = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [2:0]       cw_in,
  input  logic             cw_in_valid,
  output logic             cw_in_ready,
  input  logic [6:0]       act_in,
  input  logic             act_in_valid,
  output logic             act_in_ready,
  output logic [2:0]       cw_out,
  output logic             cw_out_valid,
  output logic [6:0]       act_out,
  output logic             act_out_valid,
  output logic             result_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(ROWS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] vec_len_q, vec_len_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [LEN_W-1:0] act_cnt_q, act_cnt_d;
  logic [2:0]       cw_out_q, cw_out_d;
  logic             cw_out_valid_q, cw_out_valid_d;
  logic [6:0]       act_out_q, act_out_d;
  logic             act_out_valid_q, act_out_valid_d;
  logic [ROWS-1:0]  res_sr_q, res_sr_d;

  logic cw_hs;
  logic act_hs;

  // Readies depend on state only, so a source can never see them react to its own valid.
  assign cw_in_ready  = (state_q == S_LOAD);
  assign act_in_ready = (state_q == S_STREAM);
  assign cw_hs        = cw_in_ready & cw_in_valid;
  assign act_hs       = act_in_ready & act_in_valid;

  assign cw_out        = cw_out_q;
  assign cw_out_valid  = cw_out_valid_q;
  assign act_out       = act_out_q;
  assign act_out_valid = act_out_valid_q;
  assign result_valid  = res_sr_q[ROWS-1];
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

  // Next-state, counter, forwarding-register and result-tracker logic.
  always_comb begin
    state_d    = state_q;
    vec_len_d  = vec_len_q;
    load_cnt_d = load_cnt_q;
    act_cnt_d  = act_cnt_q;

    // Forwarding registers: data holds between handshakes, valid is one cycle per item.
    cw_out_valid_d  = cw_hs;
    cw_out_d        = cw_hs ? cw_in : cw_out_q;
    act_out_valid_d = act_hs;
    act_out_d       = act_hs ? act_in : act_out_q;

    // One stage per CPE row; the last stage marks a finished sum at the column bottom.
    res_sr_d    = res_sr_q << 1;
    res_sr_d[0] = act_out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_len_d  = vec_len;
          load_cnt_d = '0;
          act_cnt_d  = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cw_hs) begin
          load_cnt_d = load_cnt_q + CNT_W'(1);
          if (load_cnt_q == CNT_W'(ROWS - 1)) begin
            state_d = (vec_len_q != '0) ? S_STREAM : S_DRAIN;
          end
        end
      end
      S_STREAM: begin
        if (act_hs) begin
          act_cnt_d = act_cnt_q + LEN_W'(1);
          if (act_cnt_q == vec_len_q - LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last activation may still be in the forwarding register, not yet in the tracker.
        if ((res_sr_q == '0) && !act_out_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      vec_len_q       <= '0;
      load_cnt_q      <= '0;
      act_cnt_q       <= '0;
      cw_out_q        <= '0;
      cw_out_valid_q  <= 1'b0;
      act_out_q       <= '0;
      act_out_valid_q <= 1'b0;
      res_sr_q        <= '0;
    end else begin
      state_q         <= state_d;
      vec_len_q       <= vec_len_d;
      load_cnt_q      <= load_cnt_d;
      act_cnt_q       <= act_cnt_d;
      cw_out_q        <= cw_out_d;
      cw_out_valid_q  <= cw_out_valid_d;
      act_out_q       <= act_out_d;
      act_out_valid_q <= act_out_valid_d;
      res_sr_q        <= res_sr_d;
    end
  end

endmodule

// File: tb/tb_cpe_column_sequencer.sv
// Testbench for cpe_column_sequencer with a 4-row column.
// Drivers push expected forwarded weights/activations into queues when a
// handshake is issued; a negedge monitor pops and compares whenever the
// sequencer presents a valid, and gathers per-pass timing statistics.

module tb_cpe_column_sequencer;

  localparam int ROWS  = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic [2:0]       cw_in = '0;
  logic             cw_in_valid = 1'b0;
  logic             cw_in_ready;
  logic [6:0]       act_in = '0;
  logic             act_in_valid = 1'b0;
  logic             act_in_ready;
  logic [2:0]       cw_out;
  logic             cw_out_valid;
  logic [6:0]       act_out;
  logic             act_out_valid;
  logic             result_valid;
  logic             busy;
  logic             done;

  logic [16:0] outs;
  assign outs = {cw_out, cw_out_valid, act_out, act_out_valid, cw_in_ready,
                 act_in_ready, result_valid, busy, done};

  cpe_column_sequencer #(.ROWS(ROWS), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_len      (vec_len),
    .cw_in        (cw_in),
    .cw_in_valid  (cw_in_valid),
    .cw_in_ready  (cw_in_ready),
    .act_in       (act_in),
    .act_in_valid (act_in_valid),
    .act_in_ready (act_in_ready),
    .cw_out       (cw_out),
    .cw_out_valid (cw_out_valid),
    .act_out      (act_out),
    .act_out_valid(act_out_valid),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard queues
  logic [2:0] cw_exp[$];
  logic [6:0] act_exp[$];

  // Per-pass statistics owned by the monitor
  int cyc = 0;
  int n_cw, n_act, n_res, n_done, n_ardy;
  int first_cw, last_cw, first_act, last_act, first_res, last_res, done_cyc;
  logic [ROWS-1:0] hist = '0;

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic [2:0] ecw;
    logic [6:0] eact;
    n_cw = 0; n_act = 0; n_res = 0; n_done = 0; n_ardy = 0;
    first_cw = -1; last_cw = -1; first_act = -1; last_act = -1;
    first_res = -1; last_res = -1; done_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        hist = '0;
        continue;
      end
      if (start && !busy) begin
        n_cw = 0; n_act = 0; n_res = 0; n_done = 0; n_ardy = 0;
        first_cw = -1; last_cw = -1; first_act = -1; last_act = -1;
        first_res = -1; last_res = -1; done_cyc = -1;
      end
      chk("valid_exclusion", 32'(cw_out_valid & act_out_valid), 0);
      chk("result_delay", 32'(result_valid), 32'(hist[ROWS-1]));
      hist = {hist[ROWS-2:0], act_out_valid};
      if (cw_out_valid) begin
        n_cw++;
        if (first_cw < 0) first_cw = cyc;
        last_cw = cyc;
        if (cw_exp.size() == 0) chk("cw_extra_item", 1, 0);
        else begin
          ecw = cw_exp.pop_front();
          chk("cw_out_data", 32'(cw_out), 32'(ecw));
        end
      end
      if (act_out_valid) begin
        n_act++;
        if (first_act < 0) first_act = cyc;
        last_act = cyc;
        if (act_exp.size() == 0) chk("act_extra_item", 1, 0);
        else begin
          eact = act_exp.pop_front();
          chk("act_out_data", 32'(act_out), 32'(eact));
        end
      end
      if (act_in_ready) n_ardy++;
      if (result_valid) begin
        n_res++;
        if (first_res < 0) first_res = cyc;
        last_res = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  logic [2:0] wts[4];
  logic [6:0] acts[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int v);
    tick();
    vec_len = LEN_W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_weights(input int n, input bit toggle, input bit hold_after);
    int idx = 0;
    int guard = 0;
    bit phase = 1'b1;
    while (idx < n && guard < 100) begin
      cw_in_valid = toggle ? phase : 1'b1;
      cw_in = wts[idx];
      if (cw_in_valid && cw_in_ready) begin
        cw_exp.push_back(wts[idx]);
        idx++;
      end
      phase = ~phase;
      guard++;
      tick();
    end
    if (idx < n) chk("cw_accept_timeout", idx, n);
    cw_in_valid = hold_after;
    cw_in = 3'd7;
  endtask

  task automatic send_acts(input int n, input int gap, input bit hold_after, input bit poke_start);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 100) begin
      guard++;
      act_in_valid = 1'b1;
      act_in = acts[idx];
      start = (poke_start && idx == 1);
      if (poke_start && idx == 1) vec_len = 8'd9;
      if (act_in_ready) begin
        act_exp.push_back(acts[idx]);
        idx++;
        tick();
        start = 1'b0;
        if (idx < n) begin
          for (int g = 0; g < gap; g++) begin
            act_in_valid = 1'b0;
            tick();
          end
        end
      end else begin
        tick();
      end
    end
    if (idx < n) chk("act_accept_timeout", idx, n);
    start = 1'b0;
    act_in_valid = hold_after;
    act_in = 7'd99;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 1);
    cw_in_valid = 1'b0;
    act_in_valid = 1'b0;
    tick();
    chk("idle_busy_low", 32'(busy), 0);
    chk("idle_done_low", 32'(done), 0);
  endtask

  task automatic check_pass(input int e_cw, input int e_act, input int e_res);
    tick();
    tick();
    chk("weights_forwarded", n_cw, e_cw);
    chk("acts_forwarded", n_act, e_act);
    chk("result_count", n_res, e_res);
    chk("done_pulses", n_done, 1);
    chk("cw_queue_empty", cw_exp.size(), 0);
    chk("act_queue_empty", act_exp.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Reset state
    #2 rst = 1'b0;
    #10;
    chk("reset_outputs", 32'(outs), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_reset_outputs", 32'(outs), 0);

    // Reset in the middle of LOAD
    wts[0] = 3'd1; wts[1] = 3'd2; wts[2] = 3'd3; wts[3] = 3'd4;
    do_start(3);
    send_weights(2, 1'b0, 1'b0);
    #6 rst = 1'b0;
    #1;
    chk("midload_reset_outputs", 32'(outs), 0);
    chk("midload_reset_busy", 32'(busy), 0);
    tick(); tick(); tick();
    chk("midload_no_done", n_done, 0);
    chk("midload_weights_seen", n_cw, 2);
    chk("midload_queue_empty", cw_exp.size(), 0);
    rst = 1'b1;
    tick();

    // Basic pass
    acts[0] = 7'd10; acts[1] = 7'd20; acts[2] = 7'd30;
    do_start(3);
    send_weights(4, 1'b0, 1'b1);
    send_acts(3, 0, 1'b1, 1'b0);
    wait_done();
    check_pass(4, 3, 3);
    chk("basic_cw_consecutive", last_cw - first_cw, 3);
    chk("basic_act_consecutive", last_act - first_act, 2);
    chk("basic_act_after_cw", 32'(first_act > last_cw), 1);
    chk("basic_res_latency", first_res - first_act, 4);
    chk("basic_res_consecutive", last_res - first_res, 2);

    // Bubbles on both inputs
    wts[0] = 3'd5; wts[1] = 3'd6; wts[2] = 3'd7; wts[3] = 3'd1;
    acts[0] = 7'd33; acts[1] = 7'd44;
    do_start(2);
    send_weights(4, 1'b1, 1'b0);
    send_acts(2, 2, 1'b0, 1'b0);
    wait_done();
    check_pass(4, 2, 2);
    chk("bubble_cw_spacing", last_cw - first_cw, 6);
    chk("bubble_act_gap", last_act - first_act, 3);
    chk("bubble_res_latency", first_res - first_act, 4);
    chk("bubble_res_gap", last_res - first_res, 3);

    // Zero-length pass: activations offered but never accepted
    wts[0] = 3'd2; wts[1] = 3'd4; wts[2] = 3'd6; wts[3] = 3'd3;
    do_start(0);
    send_weights(4, 1'b0, 1'b0);
    act_in_valid = 1'b1;
    act_in = 7'd55;
    wait_done();
    check_pass(4, 0, 0);
    chk("zero_act_ready_never", n_ardy, 0);
    chk("zero_done_after_drain", done_cyc - last_cw, 1);

    // start pulsed while streaming
    wts[0] = 3'd7; wts[1] = 3'd6; wts[2] = 3'd5; wts[3] = 3'd4;
    acts[0] = 7'd1; acts[1] = 7'd127; acts[2] = 7'd64;
    do_start(3);
    send_weights(4, 1'b0, 1'b1);
    send_acts(3, 0, 1'b1, 1'b1);
    wait_done();
    check_pass(4, 3, 3);
    for (int i = 0; i < 8; i++) tick();
    chk("busy_start_ignored", 32'(busy), 0);
    chk("busy_start_no_new_weights", n_cw, 4);
    chk("busy_start_one_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpe_column_sequencer.md
Name: cpe_column_sequencer

Overview:
- Controller that sequences one column of ROWS compensation processing elements.
- It runs three phases in order: preload ROWS 3-bit compensation weights down the column, stream vec_len 7-bit activations into it, then drain until the column's bottom compensation sum is valid.
- It sits between the compensation-weight memory and activation buffer on one side and the CPE column's weight, valid and activation inputs on the other.
- CPE weight-valid and activation-valid are mutually exclusive; this block guarantees they are never driven in the same cycle.

Parameters:
- ROWS, 8: number of CPEs in the column; equals the weight-load count and the drain depth.
- LEN_W, 8: width of the vec_len field and of the activation counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset. The name follows the codebase; the polarity and asynchronous behaviour are fixed.
- start  in  1  one-cycle request to run one pass. Sampled only in IDLE.
- vec_len  in  LEN_W  number of activations in this pass. Captured on an accepted start.
- cw_in  in  3  compensation weight from memory.
- cw_in_valid  in  1  cw_in is valid.
- cw_in_ready  out  1  sequencer accepts cw_in this cycle.
- act_in  in  7  activation from the activation buffer.
- act_in_valid  in  1  act_in is valid.
- act_in_ready  out  1  sequencer accepts act_in this cycle.
- cw_out  out  3  weight driven to the top CPE of the column.
- cw_out_valid  out  1  weight-pass valid to the column.
- act_out  out  7  activation driven to the column.
- act_out_valid  out  1  activation valid to the column.
- result_valid  out  1  bottom Compensation_out of the column holds a finished sum this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all counters and the valid shift register cleared. Every output is 0: cw_out, cw_out_valid, act_out, act_out_valid, cw_in_ready, act_in_ready, result_valid, busy, done.
- Reset asserted mid-pass aborts the pass immediately. There is no done pulse. On release the block is in IDLE.
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - Both readies are 0.
  - start=1 captures vec_len and goes to LOAD.
  - start is ignored in every other state (no queuing).
- LOAD:
  - cw_in_ready=1.
  - Each cycle with cw_in_valid&cw_in_ready: cw_out<=cw_in and cw_out_valid<=1 (registered, 1-cycle latency); load_cnt increments.
  - Cycles without a handshake drive cw_out_valid<=0; cw_out holds its value.
  - When the ROWS-th weight is accepted, cw_in_ready drops on the next cycle.
  - Next state is STREAM if captured vec_len!=0, otherwise DRAIN.
- STREAM:
  - act_in_ready=1 and cw_in_ready=0.
  - Each handshake: act_out<=act_in and act_out_valid<=1 (1-cycle latency); act_cnt increments.
  - Cycles without a handshake drive act_out_valid<=0.
  - After act_cnt reaches vec_len, act_in_ready=0 on the next cycle; go to DRAIN.
  - act_cnt width is LEN_W. vec_len=2^LEN_W-1 is the maximum, so no wrap occurs.
- DRAIN:
  - Both readies are 0 and no new valids are issued.
  - Stays until the result pipeline is empty, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE; busy=0 in that IDLE cycle.
- Result tracking:
  - A ROWS-bit shift register is fed by act_out_valid each cycle.
  - result_valid = its last stage, so it is act_out_valid delayed by ROWS cycles. This covers one CPE register stage per row.
  - DRAIN exits only once the shift register is all zeros.
  - With vec_len=0 no result_valid ever asserts; DRAIN lasts 1 cycle.
- Mutual exclusion: cw_out_valid and act_out_valid are never both 1.
  - The last cw_out_valid occurs in the cycle after the final weight handshake.
  - The first act_out_valid is no earlier than the cycle after that.
- Backpressure on the inputs is the source's concern. The sequencer never drops a handshaken item and never accepts more than ROWS weights or vec_len activations.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: ROWS=4; reset after 2 weights accepted.
  - Required: all outputs 0 within the reset cycle; busy=0; no done; a following start runs a clean pass.
- Basic pass:
  - Stimulus: ROWS=4, vec_len=3, cw_in_valid=1 constant with weights 1,2,3,4, then act_in_valid=1 constant with activations 10,20,30.
  - Required: cw_out_valid high for 4 consecutive cycles carrying 1,2,3,4; act_out 10,20,30 on 3 consecutive cycles; result_valid high exactly 3 cycles, starting 4 cycles after the first act_out_valid; done a single pulse; busy low afterward.
- Bubbles:
  - Stimulus: ROWS=4, vec_len=2; cw_in_valid toggling 1,0,1,0...; act_in_valid with a 2-cycle gap.
  - Required: exactly 4 weights forwarded, in order; gaps reproduced on act_out_valid and on result_valid (delayed by 4); no extra acceptance.
- Zero length:
  - Stimulus: vec_len=0.
  - Required: 4 weights loaded; act_in_ready never 1; result_valid never 1; done 1 cycle after DRAIN entry.
- start while busy:
  - Stimulus: pulse start during STREAM.
  - Required: ignored; exactly one done pulse.
- Exclusion check:
  - Stimulus: all scenarios above.
  - Required: assertion that cw_out_valid&act_out_valid is never 1, and that accepted-weight count equals ROWS per pass.
